// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
//   8N1 UART transmitter fed by a DEPTH-byte FIFO. Bytes are queued through a
//   valid/ready handshake. The serial engine pops the head whenever it is idle,
//   or at the end of a stop bit, so queued bytes go out with no idle gap.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   tx_data    byte to queue
//   tx_valid   tx_data is valid this cycle
//   tx_ready   FIFO not full; a byte is accepted when tx_valid & tx_ready
//   uart_tx    registered serial line, idle high
//   tx_busy    frame in progress or bytes still queued
//   fifo_count bytes currently queued (0..DEPTH)
//   overflow   one-cycle pulse after a byte was offered while full and dropped
module uart_tx_buffered #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     uart_tx,
  output logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(DEPTH);
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [AW:0]   FULL      = (AW + 1)'(DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            push, pop, bit_end, fifo_nonempty;

  // Handshake side: everything here depends on registered state only.
  assign tx_ready      = (fifo_count != FULL);
  assign push          = tx_valid & tx_ready;
  assign fifo_nonempty = (fifo_count != '0);
  assign bit_end       = (baud_cnt == BAUD_LAST);
  assign tx_busy       = (state != IDLE) || fifo_nonempty;

  // Next-state and pop decision.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (fifo_nonempty) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        if (bit_end && (bit_cnt == 3'd7)) state_nxt = STOP;
      end
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next frame when more bytes are waiting.
          if (fifo_nonempty) begin
            pop       = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers: FSM, pointers, counters, line and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      uart_tx    <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      state    <= state_nxt;
      overflow <= tx_valid & ~tx_ready;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      // Baud counter restarts on every frame entry so the start bit is full length.
      if ((state == IDLE) || pop) baud_cnt <= '0;
      else if (bit_end)           baud_cnt <= '0;
      else                        baud_cnt <= baud_cnt + 1'b1;

      if (pop)                           bit_cnt <= '0;
      else if ((state == DATA) && bit_end) bit_cnt <= bit_cnt + 1'b1;

      // Line follows the current state one cycle later, giving a clean register output.
      unique case (state)
        START:   uart_tx <= 1'b0;
        DATA:    uart_tx <= shreg[0];
        default: uart_tx <= 1'b1;
      endcase
    end
  end

  // Data registers: FIFO storage and transmit shift register.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
    if (pop)
      shreg <= mem[rd_ptr];
    else if ((state == DATA) && bit_end)
      shreg <= {1'b0, shreg[7:1]};
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;

  localparam int CLK_FREQ = 1050;
  localparam int BAUD     = 100;
  localparam int DEPTH    = 16;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, uart_tx, tx_busy, overflow;
  logic [4:0] fifo_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_edge = 0;
  int frames = 0;

  logic [7:0] expq[$];
  int         starts[$];
  bit         inframe = 1'b0;
  int         t = 0;
  logic       bitv = 1'b1;
  logic [7:0] rxb = 8'h00;

  uart_tx_buffered #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .uart_tx(uart_tx), .tx_busy(tx_busy),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // Receiver model: find the falling start edge, then treat the line as ten
  // DIV-cycle bit cells; every cell must hold one value, LSB-first data.
  always @(negedge clk) begin
    if (!rst_n) begin
      inframe = 1'b0;
    end else begin
      if (!inframe && uart_tx == 1'b0) begin
        inframe = 1'b1;
        t = 0;
        starts.push_back(cyc);
      end
      if (inframe) begin
        if (t % DIV == 0) begin
          bitv = uart_tx;
          if (t / DIV >= 1 && t / DIV <= 8) rxb[t / DIV - 1] = bitv;
        end
        if (t % DIV == DIV - 1) begin
          chk("bit_hold", uart_tx, bitv);
          if (t / DIV == 0) chk("start_bit", bitv, 0);
          if (t / DIV == 9) begin
            chk("stop_bit", bitv, 1);
            inframe = 1'b0;
            frames++;
            if (expq.size() == 0) chk("spurious_frame", rxb, 32'h1ff);
            else                  chk("rx_byte", rxb, expq.pop_front());
          end
        end
        t++;
      end
    end
  end

  function automatic int last_start();
    return (starts.size() > 0) ? starts[starts.size() - 1] : -1;
  endfunction

  // Called at posedge+1; offers one byte for one edge.
  task automatic send(input logic [7:0] d, output bit acc);
    tx_data  = d;
    tx_valid = 1'b1;
    acc      = tx_ready;
    acc_edge = cyc + 1;
    if (acc) expq.push_back(d);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    chk("overflow_flag", overflow, {31'b0, !acc});
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((tx_busy || inframe) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n < limit, 1);
    repeat (2) @(negedge clk);
    chk("drained", expq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state();
    chk("rst_line", uart_tx, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ready", tx_ready, 1);
  endtask

  initial begin
    bit acc;
    int a, n, n0, n_acc, refused, f0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_state();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single byte: latency, frame length, busy release
    send(8'h55, acc);
    a = acc_edge;
    chk("accept_55", acc, 1);
    chk("count_one", fifo_count, 1);
    wait_cyc(a + 3);
    chk("latency_55", last_start(), a + 2);
    wait_cyc(a + FRAME);
    chk("busy_in_frame", tx_busy, 1);
    wait_cyc(a + 1 + FRAME);
    chk("busy_fall", tx_busy, 0);
    chk("stop_still_high", uart_tx, 1);
    wait_idle(4 * FRAME);

    // Back-to-back frames with no idle gap
    n0 = starts.size();
    send(8'hA5, acc);
    send(8'h3C, acc);
    wait_idle(4 * FRAME);
    chk("b2b_frames", starts.size() - n0, 2);
    if (starts.size() >= n0 + 2) chk("b2b_gap", starts[n0 + 1] - starts[n0], FRAME);

    // Burst of 18 while idle: 17 accepted, last dropped
    n_acc = 0;
    for (int i = 0; i < 18; i++) begin
      if (i == 17) begin
        chk("full_count", fifo_count, 16);
        chk("full_ready", tx_ready, 0);
      end
      send(8'(i), acc);
      n_acc += int'(acc);
    end
    chk("drop_last", acc, 0);
    chk("burst_accepted", n_acc, 17);
    @(posedge clk);
    #1;
    chk("ovf_one_cycle", overflow, 0);
    wait_idle(20 * FRAME);

    // Full FIFO with tx_valid held across the stop-end pop
    send(8'h80, acc);
    for (int i = 1; i <= 16; i++) send(8'(8'h80 + i), acc);
    chk("full2_count", fifo_count, 16);
    chk("full2_ready", tx_ready, 0);
    refused = 0;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 2 * FRAME) begin
      send(8'h91, acc);
      if (!acc) refused++;
      n++;
    end
    chk("held_accept", acc, 1);
    a = acc_edge;
    chk("count_back_16", fifo_count, 16);
    chk("refused_some", refused > 0, 1);
    wait_cyc(a + 1);
    chk("accept_after_pop", last_start(), a);
    @(posedge clk);
    #1;
    wait_idle(30 * FRAME);

    // Reset in the start bit of a 0xFF frame with 5 bytes queued
    send(8'hFF, acc);
    a = acc_edge;
    for (int i = 0; i < 5; i++) send(8'(8'h10 + i), acc);
    wait_cyc(a + 2 + DIV / 2);
    chk("pre_reset_line", uart_tx, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state();
    expq.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    n0 = starts.size();
    repeat (30 * DIV) @(negedge clk);
    chk("no_tx_after_reset", starts.size(), n0);
    chk("idle_after_reset", tx_busy, 0);
    chk("line_after_reset", uart_tx, 1);
    @(posedge clk);
    #1;
    send(8'h3A, acc);
    a = acc_edge;
    wait_cyc(a + 3);
    chk("latency_after_reset", last_start(), a + 2);
    wait_idle(4 * FRAME);

    // Randomized traffic honouring tx_ready
    f0 = frames;
    for (int i = 0; i < 300; i++) begin
      n = 0;
      while (!tx_ready && n < 3 * FRAME) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("ready_timeout", n < 3 * FRAME, 1);
      chk("ready_rule", tx_ready, {31'b0, fifo_count != 5'd16});
      send(8'($urandom), acc);
      chk("rand_accept", acc, 1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 200)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    wait_idle(40 * FRAME);
    chk("rand_frames", frames - f0, 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
